// File: rtl/player_motion_ctrl.sv
// Player motion controller: synchronises and debounces push buttons, then moves a clamped
// (x, y) position once per video frame after a start pulse arms the game.
module player_motion_ctrl #(
    parameter int DEB_CYCLES = 50000,
    parameter int STEP       = 2,
    parameter int X_INIT     = 320,
    parameter int Y_INIT     = 240,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 638,
    parameter int Y_MAX      = 478,
    parameter int TICK_H     = 0,
    parameter int TICK_V     = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] keys,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pos_valid,
    output logic       frame_tick,
    output logic [2:0] keys_db,
    output logic       state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int             CW       = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_SAT  = {CW{1'b1}};

    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    db_q, db_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic          tick_q;
    state_t        state_q;
    logic [9:0]    x_q, y_q;
    logic          pos_valid_q;
    logic [10:0]   x_w, y_w, x_mv, y_mv;
    logic          right, down, left;

    // Debounce: a bit only flips after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            db_d[i]  = db_q[i];
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = ~db_q[i];
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != CNT_SAT) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            tick_q  <= 1'b0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= keys;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            tick_q  <= (h_count == 10'(TICK_H)) && (v_count == 10'(TICK_V));
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign right = db_q[0];
    assign down  = db_q[1];
    assign left  = db_q[2];
    assign x_w   = {1'b0, x_q};
    assign y_w   = {1'b0, y_q};

    // 11-bit arithmetic keeps the clamp comparisons free of wrap-around at both edges.
    always_comb begin
        x_mv = x_w;
        y_mv = y_w;
        if (right && !left) begin
            x_mv = (x_w > 11'(X_MAX - STEP)) ? 11'(X_MAX) : x_w + 11'(STEP);
        end else if (left && !right) begin
            x_mv = (x_w < 11'(X_MIN + STEP)) ? 11'(X_MIN) : x_w - 11'(STEP);
        end
        if (down) begin
            y_mv = (y_w > 11'(Y_MAX - STEP)) ? 11'(Y_MAX) : y_w + 11'(STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            x_q         <= 10'(X_INIT);
            y_q         <= 10'(Y_INIT);
            pos_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    x_q         <= 10'(X_INIT);
                    y_q         <= 10'(Y_INIT);
                    pos_valid_q <= 1'b0;
                    if (start) begin
                        state_q     <= PLAY;
                        pos_valid_q <= 1'b1;
                    end
                end
                PLAY: begin
                    pos_valid_q <= 1'b1;
                    if (tick_q) begin
                        x_q <= x_mv[9:0];
                        y_q <= y_mv[9:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign pos_valid  = pos_valid_q;
    assign frame_tick = tick_q;
    assign keys_db    = db_q;
    assign state_dbg  = state_q;

endmodule
